// File: rtl/serial_adder_pkg.sv
// Shared definitions for the serial adder slice.
// State encoding used by multi-cycle arithmetic blocks.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_adder.sv
// Combinational full adder.
// Two half adders chained, carries ORed.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic s0;
  logic c0;
  logic c1;

  half_adder u_ha0 (
    .a (a),
    .b (b),
    .s (s0),
    .c (c0)
  );

  half_adder u_ha1 (
    .a (s0),
    .b (cin),
    .s (s),
    .c (c1)
  );

  assign cout = c0 | c1;

endmodule

// File: rtl/half_adder.sv
// Half adder cell.
// Two of these make one full-adder bit.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first.
// One full-adder cell, carry closed through a flop.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] ps;
  logic [WIDTH-1:0] ps_nxt;
  logic             cf;
  logic [CW-1:0]    cnt;
  logic             s;
  logic             co;

  full_adder u_fa (
    .a    (sa[0]),
    .b    (sb[0]),
    .cin  (cf),
    .s    (s),
    .cout (co)
  );

  // New sum bit enters at the MSB while the partial sum shifts down.
  assign ps_nxt = (ps >> 1) | (WIDTH'(s) << (WIDTH - 1));

  // Control FSM, operand/partial-sum shifters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      carry <= 1'b0;
      sa    <= '0;
      sb    <= '0;
      ps    <= '0;
      cf    <= 1'b0;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            sa    <= a;
            sb    <= b;
            ps    <= '0;
            cf    <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ADD;
          end
        end
        ADD: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          ps  <= ps_nxt;
          cf  <= co;
          cnt <= cnt + CW'(1);
          if (cnt == CNT_LAST) begin
            sum   <= ps_nxt;
            carry <= co;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder.
// WIDTH=8 and WIDTH=1 instances share clock and reset.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       busy8;
  logic       done8;
  logic [7:0] sum8;
  logic       carry8;

  logic       start1 = 1'b0;
  logic [0:0] a1 = '0;
  logic [0:0] b1 = '0;
  logic       busy1;
  logic       done1;
  logic [0:0] sum1;
  logic       carry1;

  int errors = 0;
  int checks = 0;

  // Last result the model expects on sum/carry of the 8-bit instance.
  logic [8:0] prev8 = '0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .busy  (busy8),
    .done  (done8),
    .sum   (sum8),
    .carry (carry8)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start1),
    .a     (a1),
    .b     (b1),
    .busy  (busy1),
    .done  (done1),
    .sum   (sum1),
    .carry (carry1)
  );

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy8, done8, sum8, carry8} !== 11'h0) begin
      errors++;
      $display("FAIL reset8 got=%h want=0",
               {busy8, done8, sum8, carry8});
    end
    checks++;
    if ({busy1, done1, sum1, carry1} !== 4'h0) begin
      errors++;
      $display("FAIL reset1 got=%h want=0",
               {busy1, done1, sum1, carry1});
    end
    rst_n = 1'b1;
    prev8 = '0;
    @(posedge clk);
    #1;
  endtask

  // One addition on the 8-bit instance. With hold set, start stays
  // high and operands are scrambled during ADD, then start drops.
  task automatic do_add(input logic [7:0] x, input logic [7:0] y,
                        input bit hold, input string tag);
    logic [8:0] exp;
    int n;
    int busy_n;
    bit got;
    exp = {1'b0, x} + {1'b0, y};
    a8 = x;
    b8 = y;
    start8 = 1'b1;
    @(posedge clk);
    #1;
    if (hold) begin
      a8 = 8'hAA;
      b8 = 8'h55;
    end else begin
      start8 = 1'b0;
      a8 = 8'($urandom);
      b8 = 8'($urandom);
    end
    n = 0;
    busy_n = 0;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (busy8) busy_n++;
      if (done8) begin
        got = 1;
      end else begin
        checks++;
        if ({carry8, sum8} !== prev8) begin
          errors++;
          $display("FAIL %s hold got=%h want=%h",
                   tag, {carry8, sum8}, prev8);
        end
        @(posedge clk);
        #1;
        n++;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s timeout got=no_done want=done", tag);
    end
    checks++;
    if (n != 8) begin
      errors++;
      $display("FAIL %s latency got=%0d want=8", tag, n);
    end
    checks++;
    if (busy_n != 9) begin
      errors++;
      $display("FAIL %s busy got=%0d want=9", tag, busy_n);
    end
    checks++;
    if ({carry8, sum8} !== exp) begin
      errors++;
      $display("FAIL %s result got=%h want=%h",
               tag, {carry8, sum8}, exp);
    end
    prev8 = exp;
    start8 = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({busy8, done8} !== 2'b00) begin
      errors++;
      $display("FAIL %s post got=%b want=00", tag, {busy8, done8});
    end
  endtask

  task automatic test_basic();
    do_add(8'h5A, 8'h33, 0, "basic");
  endtask

  task automatic test_carry();
    do_add(8'hFF, 8'h01, 0, "wrap");
    do_add(8'hFF, 8'hFF, 0, "ffff");
  endtask

  task automatic test_ignore_start();
    do_add(8'h10, 8'h20, 1, "ignore");
    @(posedge clk);
    #1;
    checks++;
    if (busy8 !== 1'b0) begin
      errors++;
      $display("FAIL ignore_idle got=%b want=0", busy8);
    end
  endtask

  task automatic test_mid_reset();
    a8 = 8'hC3;
    b8 = 8'h7E;
    start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy8, done8, sum8, carry8} !== 11'h0) begin
      errors++;
      $display("FAIL midreset got=%h want=0",
               {busy8, done8, sum8, carry8});
    end
    prev8 = '0;
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_add(8'h12, 8'h34, 0, "after_rst");
  endtask

  task automatic test_back_to_back();
    int last;
    int cnt;
    bit prevd;
    a8 = 8'h01;
    b8 = 8'h01;
    start8 = 1'b1;
    last = -1;
    cnt = 0;
    prevd = 0;
    for (int c = 0; c < 45; c++) begin
      @(posedge clk);
      #1;
      if (done8) begin
        cnt++;
        checks++;
        if ({carry8, sum8} !== 9'h002) begin
          errors++;
          $display("FAIL b2b result got=%h want=002", {carry8, sum8});
        end
        checks++;
        if (prevd) begin
          errors++;
          $display("FAIL b2b double got=11 want=10");
        end
        if (last >= 0) begin
          checks++;
          if (c - last != 10) begin
            errors++;
            $display("FAIL b2b period got=%0d want=10", c - last);
          end
        end
        last = c;
      end
      prevd = done8;
    end
    start8 = 1'b0;
    checks++;
    if (cnt < 4) begin
      errors++;
      $display("FAIL b2b count got=%0d want>=4", cnt);
    end
    repeat (12) @(posedge clk);
    #1;
    prev8 = 9'h002;
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++) begin
      do_add(8'($urandom), 8'($urandom), 0, "rand");
    end
  endtask

  task automatic w1_add(input logic x, input logic y, input string tag);
    logic [1:0] exp;
    int n;
    bit got;
    exp = {1'b0, x} + {1'b0, y};
    a1 = x;
    b1 = y;
    start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    n = 0;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      if (done1) begin
        got = 1;
      end else begin
        @(posedge clk);
        #1;
        n++;
      end
    end
    checks++;
    if (!got || n != 1) begin
      errors++;
      $display("FAIL %s latency got=%0d want=1", tag, n);
    end
    checks++;
    if ({carry1, sum1} !== exp) begin
      errors++;
      $display("FAIL %s result got=%b want=%b",
               tag, {carry1, sum1}, exp);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_width1();
    w1_add(1'b1, 1'b1, "w1_11");
    w1_add(1'b0, 1'b1, "w1_01");
    w1_add(1'b1, 1'b0, "w1_10");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_ignore_start();
    test_mid_reset();
    test_back_to_back();
    test_random();
    test_width1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
